// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Optional leading-zero blanking is selected in seg_scan_ctrl by SEG_SCAN_LZB_EN.
package seg_scan_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [3:0]  BLANK_CODE = 4'hF;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] bcd_t;

    typedef enum logic {
        EMPTY,
        PENDING
    } buf_state_t;

endpackage

// File: rtl/scan_prescaler.sv
// Refresh-rate prescaler: free-running 0..REFRESH_DIV-1 counter with a
// single-cycle tick while the count sits at its terminal value.
module scan_prescaler #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);

    logic [DIV_W-1:0] r_count;

    assign tick = (r_count == DIV_W'(REFRESH_DIV - 1));

    // Count up, wrapping to zero on the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-synchronous reload.
// Define SEG_SCAN_LZB_EN to blank leading zeros (digit 0 is never blanked).
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [1:0]  digit_sel,
    output logic [3:0]  bcd_out,
    output logic        frame_done
);

    logic        w_tick;
    logic        w_frame;
    logic        w_load_acc;
    logic        w_commit;
    logic [15:0] w_src;
    digit_idx_t  w_digit_next;
    bcd_t        w_bcd_next;
    buf_state_t  r_state;
    buf_state_t  w_state_next;
    logic [15:0] r_shadow;
    logic [15:0] r_active;
    digit_idx_t  r_digit_sel;
    bcd_t        r_bcd;
    logic        r_frame_done;

    scan_prescaler #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .tick(w_tick)
    );

    assign w_frame      = w_tick && (r_digit_sel == digit_idx_t'(NUM_DIGITS - 1));
    assign w_digit_next = r_digit_sel + digit_idx_t'(1);
    // On a committing boundary the new value is shown straight away on digit 0.
    assign w_src        = w_commit ? r_shadow : r_active;

    assign load_ready = (r_state == EMPTY);
    assign digit_sel  = r_digit_sel;
    assign bcd_out    = r_bcd;
    assign frame_done = r_frame_done;

    // Buffer FSM next state: accept into shadow when empty, commit at frame boundary.
    always_comb begin
        w_state_next = r_state;
        w_load_acc   = 1'b0;
        w_commit     = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (load) begin
                    w_load_acc   = 1'b1;
                    w_state_next = PENDING;
                end
            end
            PENDING: begin
                if (w_frame) begin
                    w_commit     = 1'b1;
                    w_state_next = EMPTY;
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    // Buffer FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shadow capture and active-buffer commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_active <= '1;
        end else begin
            if (w_load_acc) begin
                r_shadow <= load_data;
            end
            if (w_commit) begin
                r_active <= r_shadow;
            end
        end
    end

    // Nibble for the digit about to be selected, with optional leading-zero blanking.
    always_comb begin
        w_bcd_next = w_src[{w_digit_next, 2'b00} +: 4];
`ifdef SEG_SCAN_LZB_EN
        if ((w_digit_next != '0) && ((w_src >> {w_digit_next, 2'b00}) == '0)) begin
            w_bcd_next = BLANK_CODE;
        end
`endif
    end

    // Digit select and nibble advance together on each tick; frame pulse follows the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit_sel  <= '0;
            r_bcd        <= BLANK_CODE;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame;
            if (w_tick) begin
                r_digit_sel <= w_digit_next;
                r_bcd       <= w_bcd_next;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (REFRESH_DIV=4).
// Honours SEG_SCAN_LZB_EN in its expected display values.
module tb_seg_scan_ctrl;

    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] load_data;
    logic        load_ready;
    logic [1:0]  digit_sel;
    logic [3:0]  bcd_out;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .REFRESH_DIV(DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .load_ready(load_ready),
        .digit_sel (digit_sel),
        .bcd_out   (bcd_out),
        .frame_done(frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time measured in clock edges since reset release.
    int unsigned n_edges;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    bit          m_pend;
    bit          m_frame;

    typedef struct {
        logic [15:0] data;
        logic [15:0] shown;   // expected nibble per digit, digit k at [4k+:4]
    } vec_t;

    vec_t tbl [5];

    function automatic logic [3:0] disp(logic [15:0] v, int d);
        logic [3:0] nib;
        nib = v[d*4 +: 4];
`ifdef SEG_SCAN_LZB_EN
        if (d > 0 && (v >> (4 * d)) == 16'h0) nib = 4'hF;
`endif
        return nib;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, n_edges, $time);
        end
    endtask

    task automatic compare_all();
        int d;
        d = int'((n_edges / DIV) % 4);
        chk("digit_sel", 32'(digit_sel), 32'(d));
        chk("bcd_out", 32'(bcd_out), 32'(disp(m_active, d)));
        chk("load_ready", 32'(load_ready), 32'(!m_pend));
        chk("frame_done", 32'(frame_done), 32'(m_frame));
    endtask

    task automatic step(bit ld, logic [15:0] data);
        bit boundary;
        bit acc;
        load      = ld;
        load_data = data;
        @(posedge clk);
        n_edges++;
        boundary = (n_edges % FRAME) == 0;
        acc      = ld && !m_pend;
        if (boundary && m_pend) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
        end
        if (acc) begin
            m_shadow = data;
            m_pend   = 1'b1;
        end
        m_frame = boundary;
        #1;
        compare_all();
        load = 1'b0;
    endtask

    task automatic do_reset();
        load      = 1'b0;
        load_data = '0;
        rst       = 1'b1;
        n_edges   = 0;
        m_active  = 16'hFFFF;
        m_shadow  = '0;
        m_pend    = 1'b0;
        m_frame   = 1'b0;
        #1;
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        compare_all();
    endtask

    task automatic wait_commit();
        for (int i = 0; i < 4 * FRAME && m_pend; i++) step(1'b0, '0);
        if (m_pend) chk("commit_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_phase(int unsigned ph);
        for (int i = 0; i < FRAME && (n_edges % FRAME) != ph; i++) step(1'b0, '0);
    endtask

    initial begin
        int frames;
        tbl[0] = '{16'h1234, 16'h1234};
        tbl[3] = '{16'hABCD, 16'hABCD};
`ifdef SEG_SCAN_LZB_EN
        tbl[1] = '{16'h0070, 16'hFF70};
        tbl[2] = '{16'h0000, 16'hFFF0};
        tbl[4] = '{16'h0105, 16'hF105};
`else
        tbl[1] = '{16'h0070, 16'h0070};
        tbl[2] = '{16'h0000, 16'h0000};
        tbl[4] = '{16'h0105, 16'h0105};
`endif

        // Reset state and free-running scan.
        do_reset();
        chk("reset_bcd_blank", 32'(bcd_out), 32'hF);
        frames = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, '0);
            if (frame_done) frames++;
        end
        chk("frame_pulse_count", 32'(frames), 32'd2);

        // Table of loaded values against expected per-digit display.
        for (int v = 0; v < 5; v++) begin
            step(1'b1, tbl[v].data);
            chk("ready_low_after_load", 32'(load_ready), 32'd0);
            wait_commit();
            for (int k = 0; k < 4; k++) begin
                chk("tbl_digit_sel", 32'(digit_sel), 32'(k));
                chk("tbl_bcd", 32'(bcd_out), 32'(tbl[v].shown[4*k +: 4]));
                for (int j = 0; j < int'(DIV); j++) step(1'b0, '0);
            end
            chk("tbl_ready_back", 32'(load_ready), 32'd1);
        end

        // Second load while pending is dropped.
        step(1'b1, 16'h1234);
        step(1'b1, 16'h5678);
        wait_commit();
        for (int i = 0; i < 2 * FRAME; i++) begin
            chk("never_5678", 32'(bcd_out >= 4'd1 && bcd_out <= 4'd4), 32'd1);
            step(1'b0, '0);
        end

        // Load in EMPTY on the exact boundary cycle waits a full frame.
        wait_phase(FRAME - 1);
        step(1'b1, 16'h9999);
        chk("bnd_load_not_committed", 32'(bcd_out), 32'h4);
        chk("bnd_load_pending", 32'(load_ready), 32'd0);
        for (int i = 0; i < int'(FRAME) - 1; i++) step(1'b0, '0);
        chk("bnd_still_pending", 32'(load_ready), 32'd0);
        step(1'b0, '0);
        chk("bnd_committed", 32'(bcd_out), 32'h9);
        chk("bnd_ready", 32'(load_ready), 32'd1);

        // Async reset while pending on digit 2 discards the shadow.
        wait_phase(0);
        step(1'b1, 16'h4321);
        wait_phase(2 * DIV);
        chk("pre_reset_digit", 32'(digit_sel), 32'd2);
        #2;
        do_reset();
        for (int i = 0; i < 2 * FRAME; i++) step(1'b0, '0);

        // Randomised traffic checked against the model every cycle.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit seven-segment display. It holds a 4-digit BCD value and steps through the digits at a programmable refresh rate. Each step drives a 2-bit digit select and the matching 4-bit BCD nibble into the downstream anode-decoder/BCD-to-cathode stage. A new value is loaded with a valid/ready handshake and is applied only at a frame boundary, so the display never shows a mix of old and new digits.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit stays active; legal range 2..2^24.
DIV_W, $clog2(REFRESH_DIV), prescaler counter width; derived, not overridden.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
load  in  1  load request; accepted only when load_ready=1
load_data  in  16  four BCD nibbles; [3:0]=digit0 (rightmost), [15:12]=digit3
load_ready  out  1  high when the shadow buffer is free
digit_sel  out  2  active digit index; drives the anode decoder select
bcd_out  out  4  BCD nibble for digit_sel; drives the cathode decoder
frame_done  out  1  one-cycle pulse when digit 3→0 wrap occurs

Behaviour:
- Reset (async, rst=1) values:
  - prescaler=0, digit_sel=0, bcd_out=4'hF (blank code).
  - active buffer=16'hFFFF (all digits blank), shadow=0.
  - buffer FSM=EMPTY, load_ready=1, frame_done=0.
- Reset mid-operation aborts any pending load; the shadow contents are discarded.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps to 0. tick=1 in the cycle where the count equals REFRESH_DIV-1.
- On tick:
  - digit_sel <= digit_sel+1 (mod 4).
  - bcd_out <= the active-buffer nibble for the new digit_sel.
  - digit_sel and bcd_out are both registered and update in the same cycle, so they are always a consistent pair.
- Frame boundary = a tick while digit_sel==3:
  - digit_sel wraps to 0.
  - frame_done=1 for exactly that cycle.
  - If FSM=PENDING: active <= shadow, FSM→EMPTY. The digit-0 nibble presented on that tick comes from the newly committed value.
- Buffer FSM:
  - EMPTY: load_ready=1. load=1 → shadow <= load_data, FSM→PENDING.
  - PENDING: load_ready=0. load is ignored and the data is dropped. Frame boundary → commit, FSM→EMPTY.
- Simultaneous load and frame boundary:
  - In PENDING, the load is ignored; the commit uses the existing shadow; load_ready rises the next cycle.
  - In EMPTY, the load is captured into shadow but not committed until the following frame boundary.
- Nibbles 10..15 pass through unchanged; the downstream decoder blanks them.
- Latency:
  - load accept → visible on digit 0 at the next frame boundary, worst case 4·REFRESH_DIV cycles.
  - tick → output change 0 cycles (registered on the tick edge).

Optional Feature:
SEG_SCAN_LZB_EN, leading-zero blanking.
- Defined: when a nibble is loaded into bcd_out, any digit whose value is 0 and is more significant than the highest non-zero digit outputs 4'hF instead. Digit 0 is never blanked. Example: value 0x0070 displays as blank, blank, 7, 0.
- Undefined: nibbles are always presented exactly as stored.

Decomposition:
- Package seg_scan_pkg holds:
  - NUM_DIGITS=4
  - BLANK_CODE=4'hF
  - typedef digit_idx_t (2-bit)
  - typedef bcd_t (4-bit)
  - typedef buf_state_t {EMPTY, PENDING}
- Sub-module scan_prescaler (parameter REFRESH_DIV; ports clk, rst, tick). It is instantiated once.
- Nibble select, blanking and the buffer FSM stay in seg_scan_ctrl.

Test Plan:
1. REFRESH_DIV=4, release reset → digit_sel=0, bcd_out=F, load_ready=1. digit_sel steps 0,1,2,3,0 every 4 cycles. frame_done pulses once every 16 cycles.
2. load=1, load_data=16'h1234 in EMPTY → load_ready=0 the next cycle. After the next frame boundary, the sequence per digit_sel 0..3 is bcd_out 4,3,2,1. load_ready returns to 1.
3. load 16'h1234, then load 16'h5678 while PENDING → the second load is ignored. Display shows 1234 and never 5678.
4. Issue load=1 in EMPTY on the exact frame-boundary cycle with 16'h9999 → not committed that boundary. Committed at the next one, 16 cycles later.
5. Assert rst while PENDING with digit_sel=2 → all outputs return to reset values immediately (async). The pending value is never displayed.
6. SEG_SCAN_LZB_EN defined, load 16'h0070 → digit 0..3 outputs 0,7,F,F. With 16'h0000 → 0,F,F,F. Without the macro, 16'h0070 → 0,7,0,0.
